// File: rtl/tx_resp_arbiter_pkg.sv
// Shared definitions for the TX response arbiter: FSM state encoding,
// source identifiers and the drop-counter saturation limit.
package tx_resp_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_REG    = 2'd1,
    SEND_ALU_LO = 2'd2,
    SEND_ALU_HI = 2'd3
  } state_e;

  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_ALU = 1'b1
  } src_e;

  localparam int unsigned DROP_CNT_MAX = 255;

endpackage

// File: rtl/tx_resp_arbiter_slot.sv
// Single-entry holding slot for one pending response. A load in the same
// cycle as a free refills the slot; a load into a held slot is dropped.
module resp_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] din_i,
  input  logic         free_i,
  output logic         full_o,
  output logic [W-1:0] data_o,
  output logic         drop_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (free_i) full_d = 1'b0;
    if (load_i && (!full_q || free_i)) begin
      full_d = 1'b1;
      data_d = din_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign drop_o = load_i & full_q & ~free_i;

endmodule

// File: rtl/tx_resp_arbiter.sv
// Arbitrates REG (1 byte) and ALU (2 byte) responses into a byte FIFO.
// Optional saturating drop counter enabled by TX_RESP_ARBITER_DROP_CNT_EN.
module tx_resp_arbiter
  import tx_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_Valid,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic                    wfull,
  input  logic                    ovf_clr,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    busy,
  output logic                    overflow,
  output logic [1:0]              state_dbg
`ifdef TX_RESP_ARBITER_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt
`endif
);

  state_e                  state_q, state_d;
  src_e                    rr_q, rr_d;
  logic                    overflow_q, overflow_d;
  logic                    reg_full, alu_full, reg_drop, alu_drop;
  logic                    reg_free, alu_free;
  logic [DATA_WIDTH-1:0]   reg_data;
  logic [2*DATA_WIDTH-1:0] alu_data;

  resp_slot #(.W(DATA_WIDTH)) u_reg_slot (
    .clk(CLK), .rst_n(RST), .load_i(RdData_Valid), .din_i(RdData),
    .free_i(reg_free), .full_o(reg_full), .data_o(reg_data), .drop_o(reg_drop)
  );

  resp_slot #(.W(2*DATA_WIDTH)) u_alu_slot (
    .clk(CLK), .rst_n(RST), .load_i(OUT_Valid), .din_i(ALU_OUT),
    .free_i(alu_free), .full_o(alu_full), .data_o(alu_data), .drop_o(alu_drop)
  );

  // Write handshake: a byte transfers on every edge where TX_D_VLD is high;
  // wfull is the back-pressure and freezes state and TX_P_DATA while set.
  // rr_q only moves on contested grants; an uncontested grant keeps fairness.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    TX_D_VLD  = 1'b0;
    TX_P_DATA = '0;
    reg_free  = 1'b0;
    alu_free  = 1'b0;
    case (state_q)
      IDLE: begin
        if (reg_full && alu_full) begin
          if (rr_q == SRC_ALU) begin
            state_d = SEND_REG;
            rr_d    = SRC_REG;
          end else begin
            state_d = SEND_ALU_LO;
            rr_d    = SRC_ALU;
          end
        end else if (reg_full) begin
          state_d = SEND_REG;
        end else if (alu_full) begin
          state_d = SEND_ALU_LO;
        end
      end
      SEND_REG: begin
        TX_D_VLD  = ~wfull;
        TX_P_DATA = reg_data;
        if (TX_D_VLD) begin
          state_d  = IDLE;
          reg_free = 1'b1;
        end
      end
      SEND_ALU_LO: begin
        TX_D_VLD  = ~wfull;
        TX_P_DATA = alu_data[DATA_WIDTH-1:0];
        if (TX_D_VLD) state_d = SEND_ALU_HI;
      end
      SEND_ALU_HI: begin
        TX_D_VLD  = ~wfull;
        TX_P_DATA = alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
        if (TX_D_VLD) begin
          state_d  = IDLE;
          alu_free = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop in the same cycle as a clear wins so no loss goes unreported.
  assign overflow_d = reg_drop | alu_drop | (overflow_q & ~ovf_clr);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      rr_q       <= SRC_REG;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign busy      = reg_full | alu_full | (state_q != IDLE);
  assign state_dbg = state_q;

`ifdef TX_RESP_ARBITER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [8:0] drop_sum;

  always_comb begin
    drop_sum   = (ovf_clr ? 9'd0 : {1'b0, drop_cnt_q})
               + {8'd0, reg_drop} + {8'd0, alu_drop};
    drop_cnt_d = (drop_sum > 9'(DROP_CNT_MAX)) ? 8'(DROP_CNT_MAX) : drop_sum[7:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Self-checking bench for tx_resp_arbiter: queue-based reference model compared
// every cycle, plus directed scenarios with literal byte-sequence expectations.
module tb_tx_resp_arbiter;

  localparam int DW = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic [2*DW-1:0] ALU_OUT;
  logic            OUT_Valid;
  logic [DW-1:0]   RdData;
  logic            RdData_Valid;
  logic            wfull;
  logic            ovf_clr;
  logic [DW-1:0]   TX_P_DATA;
  logic            TX_D_VLD;
  logic            busy;
  logic            overflow;
  logic [1:0]      state_dbg;
`ifdef TX_RESP_ARBITER_DROP_CNT_EN
  logic [7:0]      drop_cnt;
`endif

  tx_resp_arbiter #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .wfull(wfull),
    .ovf_clr(ovf_clr), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .busy(busy), .overflow(overflow), .state_dbg(state_dbg)
`ifdef TX_RESP_ARBITER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model: bytes still owed to the FIFO, plus the two pending responses
  logic [DW-1:0]   exp_q[$];
  bit              cur_alu;
  bit              m_reg_full, m_alu_full, m_alu_won, m_ovf;
  logic [DW-1:0]   m_reg_d;
  logic [2*DW-1:0] m_alu_d;
  int              m_cnt;

  logic [DW-1:0]   log_q[$];
  int              log_cyc[$];
  logic [DW-1:0]   want_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    cur_alu    = 1'b0;
    m_reg_full = 1'b0;
    m_alu_full = 1'b0;
    m_alu_won  = 1'b0;
    m_ovf      = 1'b0;
    m_reg_d    = '0;
    m_alu_d    = '0;
    m_cnt      = 0;
  endfunction

  function automatic void model_step();
    bit idle, wr, done, occ_r, occ_a, dr, da;
    idle  = (exp_q.size() == 0);
    wr    = !idle && !wfull;
    done  = wr && (exp_q.size() == 1);
    if (wr) void'(exp_q.pop_front());
    occ_r = m_reg_full && !(done && !cur_alu);
    occ_a = m_alu_full && !(done && cur_alu);
    dr    = RdData_Valid && occ_r;
    da    = OUT_Valid && occ_a;
    if (idle && (m_reg_full || m_alu_full)) begin
      if (m_reg_full && m_alu_full) begin
        cur_alu   = !m_alu_won;
        m_alu_won = cur_alu;
      end else begin
        cur_alu = m_alu_full;
      end
      if (cur_alu) begin
        exp_q.push_back(m_alu_d[DW-1:0]);
        exp_q.push_back(m_alu_d[2*DW-1:DW]);
      end else begin
        exp_q.push_back(m_reg_d);
      end
    end
    if (RdData_Valid && !occ_r) begin
      m_reg_full = 1'b1;
      m_reg_d    = RdData;
    end else m_reg_full = occ_r;
    if (OUT_Valid && !occ_a) begin
      m_alu_full = 1'b1;
      m_alu_d    = ALU_OUT;
    end else m_alu_full = occ_a;
    if (dr || da) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (ovf_clr) m_cnt = 0;
    m_cnt = m_cnt + int'(dr) + int'(da);
    if (m_cnt > 255) m_cnt = 255;
  endfunction

  // scoreboard: model advances on posedge, outputs compared on negedge
  initial begin
    model_reset();
    forever begin
      @(posedge CLK);
      cyc++;
      if (!RST) model_reset();
      else model_step();
      @(negedge CLK);
      if (!RST) model_reset();
      check("tx_d_vld", TX_D_VLD, (exp_q.size() > 0) && !wfull);
      check("tx_p_data", TX_P_DATA, (exp_q.size() > 0) ? exp_q[0] : '0);
      check("busy", busy, (exp_q.size() > 0) || m_reg_full || m_alu_full);
      check("overflow", overflow, m_ovf);
`ifdef TX_RESP_ARBITER_DROP_CNT_EN
      check("drop_cnt", drop_cnt, m_cnt);
`endif
      if (TX_D_VLD === 1'b1) begin
        log_q.push_back(TX_P_DATA);
        log_cyc.push_back(cyc);
      end
    end
  end

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic reg_strobe(input logic [DW-1:0] d);
    RdData       = d;
    RdData_Valid = 1'b1;
    step();
    RdData_Valid = 1'b0;
  endtask

  task automatic alu_strobe(input logic [2*DW-1:0] d);
    ALU_OUT   = d;
    OUT_Valid = 1'b1;
    step();
    OUT_Valid = 1'b0;
  endtask

  task automatic check_log(input string name);
    check($sformatf("%s_len", name), log_q.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), log_q[i], want_q[i]);
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  int k;

  initial begin
    RST = 1'b0; ALU_OUT = '0; OUT_Valid = 1'b0; RdData = '0;
    RdData_Valid = 1'b0; wfull = 1'b0; ovf_clr = 1'b0;
    step(2);
    #1;
    check("rst_vld", TX_D_VLD, 1'b0);
    check("rst_data", TX_P_DATA, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    RST = 1'b1;
    step(2);

    // single REG response and its latency
    clear_log();
    reg_strobe(8'hA5);
    k = cyc;
    step(4);
    want_q = '{8'hA5};
    check_log("reg_single");
    if (log_cyc.size() > 0) check("reg_latency", log_cyc[0], k + 1);
    check("reg_busy_done", busy, 1'b0);

    // ALU response: low byte then high byte on consecutive cycles
    clear_log();
    alu_strobe(16'h1234);
    k = cyc;
    step(5);
    want_q = '{8'h34, 8'h12};
    check_log("alu_pair");
    if (log_cyc.size() == 2) begin
      check("alu_lo_cycle", log_cyc[0], k + 1);
      check("alu_hi_cycle", log_cyc[1], k + 2);
    end

    // simultaneous strobes after reset: ALU first, then round-robin favours REG
    RST = 1'b0;
    step(1);
    RST = 1'b1;
    step(1);
    clear_log();
    RdData = 8'h55; RdData_Valid = 1'b1; ALU_OUT = 16'hBEEF; OUT_Valid = 1'b1;
    step();
    RdData_Valid = 1'b0; OUT_Valid = 1'b0;
    step(8);
    want_q = '{8'hEF, 8'hBE, 8'h55};
    check_log("rr_first");
    clear_log();
    RdData_Valid = 1'b1; OUT_Valid = 1'b1;
    step();
    RdData_Valid = 1'b0; OUT_Valid = 1'b0;
    step(8);
    want_q = '{8'h55, 8'hEF, 8'hBE};
    check_log("rr_second");

    // back-pressure for 5 cycles while the high byte is pending
    clear_log();
    alu_strobe(16'hABCD);
    step(2);
    wfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall_vld%0d", i), TX_D_VLD, 1'b0);
      check($sformatf("stall_data%0d", i), TX_P_DATA, 8'hAB);
      step();
    end
    wfull = 1'b0;
    step(4);
    want_q = '{8'hCD, 8'hAB};
    check_log("stall_bytes");
    if (log_cyc.size() == 2) check("stall_gap", log_cyc[1] - log_cyc[0], 6);

    // second REG strobe while the first is stuck: dropped, overflow set
    clear_log();
    wfull = 1'b1;
    reg_strobe(8'h11);
    step(2);
    reg_strobe(8'h22);
    #1;
    check("drop_ovf", overflow, 1'b1);
`ifdef TX_RESP_ARBITER_DROP_CNT_EN
    check("drop_cnt_one", drop_cnt, 8'd1);
`endif
    wfull = 1'b0;
    step(4);
    want_q = '{8'h11};
    check_log("drop_keep_first");
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    #1;
    check("ovf_cleared", overflow, 1'b0);

    // clear and drop on the same edge: the drop wins
    clear_log();
    wfull = 1'b1;
    reg_strobe(8'h33);
    step(2);
    RdData = 8'h44; RdData_Valid = 1'b1; ovf_clr = 1'b1;
    step();
    RdData_Valid = 1'b0; ovf_clr = 1'b0;
    #1;
    check("clr_drop_ovf", overflow, 1'b1);
    wfull = 1'b0;
    step(4);
    want_q = '{8'h33};
    check_log("clr_drop_bytes");
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;

    // strobe on the edge its slot is freed is accepted
    clear_log();
    reg_strobe(8'hC1);
    step(1);
    reg_strobe(8'hC2);
    step(5);
    want_q = '{8'hC1, 8'hC2};
    check_log("refill_on_free");
    check("refill_no_ovf", overflow, 1'b0);

    // reset between the ALU low and high byte writes
    clear_log();
    alu_strobe(16'h5A6B);
    step(2);
    RST = 1'b0;
    #1;
    check("midrst_vld", TX_D_VLD, 1'b0);
    check("midrst_data", TX_P_DATA, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ovf", overflow, 1'b0);
    step();
    RST = 1'b1;
    step(6);
    want_q = '{8'h6B};
    check_log("midrst_bytes");
    check("midrst_idle", busy, 1'b0);

`ifdef TX_RESP_ARBITER_DROP_CNT_EN
    // drop counter saturates at 255
    wfull = 1'b1;
    reg_strobe(8'h77);
    RdData_Valid = 1'b1;
    step(260);
    RdData_Valid = 1'b0;
    #1;
    check("drop_cnt_sat", drop_cnt, 8'd255);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    #1;
    check("drop_cnt_clr", drop_cnt, 8'd0);
    wfull = 1'b0;
    step(4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
